// File: rtl/mem_responder.sv
// Single-port memory responder with a req/ack handshake and WAIT_STATES wait
// cycles between acceptance and response.
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   req, we           : request valid and write select (sampled at acceptance)
//   addr, wdata       : word address and write data (sampled at acceptance)
//   rdata             : registered read data, updated only by read accesses
//   ack               : one-cycle completion pulse in the RESP cycle
//   busy              : high whenever a transaction is in flight
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 13,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;

  logic                  access_c;
  logic                  acc_we_c;
  logic [ADDR_WIDTH-1:0] acc_addr_c;
  logic [DATA_WIDTH-1:0] acc_wdata_c;
  logic                  mem_we_c;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array: not cleared by reset, but a reset on the access edge blocks the commit.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_c) begin
      mem_q[acc_addr_c] <= acc_wdata_c;
    end
  end

  // Next-state logic; access_c marks the edge on which the array is touched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    access_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
          cnt_d   = CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            access_c = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_RESP;
          access_c = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic; with zero wait states the access uses the live inputs on the acceptance edge.
  always_comb begin
    acc_we_c    = we_q;
    acc_addr_c  = addr_q;
    acc_wdata_c = wdata_q;
    if (state_q == S_IDLE) begin
      acc_we_c    = we;
      acc_addr_c  = addr;
      acc_wdata_c = wdata;
    end
    mem_we_c = access_c && acc_we_c;
    rdata_d  = rdata_q;
    if (access_c && !acc_we_c) begin
      rdata_d = mem_q[acc_addr_c];
    end
    ack_d  = (state_d == S_RESP);
    busy_d = (state_d != S_IDLE);
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: instance A with two wait states, instance B with none,
// both compared against a memory model and the W+1 request-to-ack latency.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, we_a, ack_a, busy_a;
  logic [12:0] addr_a;
  logic [7:0]  wdata_a, rdata_a;
  logic        req_b, we_b, ack_b, busy_b;
  logic [12:0] addr_b;
  logic [7:0]  wdata_b, rdata_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0]  model_a [logic [12:0]];
  logic [7:0]  model_b [logic [12:0]];
  logic [7:0]  exp_rd_a = 8'h00;
  logic [7:0]  exp_rd_b = 8'h00;
  logic [12:0] wr_a [$];
  logic [12:0] wr_b [$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .rdata(rdata_a), .ack(ack_a), .busy(busy_a)
  );

  mem_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .rdata(rdata_b), .ack(ack_b), .busy(busy_b)
  );

  function automatic logic obs_ack(input bit sel);
    return sel ? ack_b : ack_a;
  endfunction

  function automatic logic obs_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic [7:0] obs_rdata(input bit sel);
    return sel ? rdata_b : rdata_a;
  endfunction

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [12:0] a, input logic [7:0] d);
    if (sel) begin
      req_b = r; we_b = w; addr_b = a; wdata_b = d;
    end else begin
      req_a = r; we_a = w; addr_a = a; wdata_a = d;
    end
  endtask

  // One isolated transaction: ack only in cycle W+1, busy in 1..W+1, rdata as modelled.
  task automatic txn(input bit sel, input logic w, input logic [12:0] a,
                     input logic [7:0] d, input string name);
    int         wst;
    logic [7:0] exp;
    wst = sel ? 0 : 2;
    @(negedge clk);
    total_cnt++;
    if (obs_busy(sel) !== 1'b0) $display("FAIL %s idle_busy got %b want 0", name, obs_busy(sel));
    else pass_cnt++;
    drive(sel, 1'b1, w, a, d);
    if (w) begin
      if (sel) model_b[a] = d; else model_a[a] = d;
    end else begin
      if (sel) exp_rd_b = model_b[a]; else exp_rd_a = model_a[a];
    end
    exp = sel ? exp_rd_b : exp_rd_a;
    for (int k = 1; k <= wst + 2; k++) begin
      @(negedge clk);
      if (k == 1) drive(sel, 1'b0, w, a, d);
      total_cnt++;
      if (obs_ack(sel) !== (k == wst + 1))
        $display("FAIL %s ack cycle %0d got %b want %b", name, k, obs_ack(sel), (k == wst + 1));
      else pass_cnt++;
      total_cnt++;
      if (obs_busy(sel) !== (k <= wst + 1))
        $display("FAIL %s busy cycle %0d got %b want %b", name, k, obs_busy(sel), (k <= wst + 1));
      else pass_cnt++;
      if (k == wst + 1) begin
        total_cnt++;
        if (obs_rdata(sel) !== exp)
          $display("FAIL %s rdata got %h want %h", name, obs_rdata(sel), exp);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({ack_a, busy_a, rdata_a} !== 10'd0 || {ack_b, busy_b, rdata_b} !== 10'd0)
        $display("FAIL reset_outputs a=%b%b%h b=%b%b%h want all zero",
                 ack_a, busy_a, rdata_a, ack_b, busy_b, rdata_b);
      else pass_cnt++;
    end
    rst = 1'b0;
    model_a[13'h0100] = 8'h77;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_a = 1'b0;
      total_cnt++;
      if (ack_a !== (k == 3) || busy_a !== (k <= 3) || rdata_a !== 8'h00)
        $display("FAIL reset_first_accept cycle %0d got ack=%b busy=%b rdata=%h want ack=%b busy=%b rdata=00",
                 k, ack_a, busy_a, rdata_a, (k == 3), (k <= 3));
      else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    txn(1'b0, 1'b1, 13'h0010, 8'hA5, "wr_0010");
    txn(1'b0, 1'b0, 13'h0010, 8'h00, "rd_0010");
  endtask

  task automatic test_back_to_back();
    int acks [$];
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 13'h1FFF, 8'h3C);
    model_a[13'h1FFF] = 8'h3C;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) we_a = 1'b0;
      if (k == 5) req_a = 1'b0;
      if (ack_a === 1'b1) acks.push_back(k);
      if (k == 4) begin
        total_cnt++;
        if (busy_a !== 1'b0) $display("FAIL b2b_idle_gap busy got %b want 0", busy_a);
        else pass_cnt++;
      end
      if (k == 7) begin
        total_cnt++;
        if (ack_a !== 1'b1 || rdata_a !== 8'h3C)
          $display("FAIL b2b_read got ack=%b rdata=%h want ack=1 rdata=3c", ack_a, rdata_a);
        else pass_cnt++;
      end
    end
    exp_rd_a = 8'h3C;
    total_cnt++;
    if (acks.size() != 2) $display("FAIL b2b_ack_count got %0d want 2", acks.size());
    else pass_cnt++;
    if (acks.size() == 2) begin
      total_cnt++;
      if (acks[0] != 3 || acks[1] - acks[0] != 4)
        $display("FAIL b2b_spacing got first=%0d gap=%0d want first=3 gap=4", acks[0], acks[1] - acks[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_input_change();
    txn(1'b0, 1'b1, 13'h0001, 8'h11, "pre_0001");
    txn(1'b0, 1'b1, 13'h0002, 8'h22, "pre_0002");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 13'h0001, 8'h99);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b0, 1'b0, 1'b1, 13'h0002, 8'h99);
      if (k == 3) begin
        total_cnt++;
        if (ack_a !== 1'b1 || rdata_a !== 8'h11)
          $display("FAIL change_read got ack=%b rdata=%h want ack=1 rdata=11", ack_a, rdata_a);
        else pass_cnt++;
      end
    end
    exp_rd_a = 8'h11;
    txn(1'b0, 1'b0, 13'h0002, 8'h00, "change_no_write");
  endtask

  task automatic test_reset_mid_write();
    txn(1'b0, 1'b1, 13'h0020, 8'h00, "pre_0020");
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 13'h0020, 8'hFF);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_a = 1'b0;
      if (k == 2) rst = 1'b1;
      if (k >= 3) begin
        total_cnt++;
        if (ack_a !== 1'b0 || busy_a !== 1'b0 || rdata_a !== 8'h00)
          $display("FAIL reset_abort cycle %0d got ack=%b busy=%b rdata=%h want 0 0 00",
                   k, ack_a, busy_a, rdata_a);
        else pass_cnt++;
        rst = 1'b0;
      end
    end
    exp_rd_a = 8'h00;
    exp_rd_b = 8'h00;
    txn(1'b0, 1'b0, 13'h0020, 8'h00, "reset_no_commit");
  endtask

  task automatic test_w0();
    int acks [$];
    txn(1'b1, 1'b1, 13'h0005, 8'h5A, "w0_wr_0005");
    txn(1'b1, 1'b0, 13'h0005, 8'h00, "w0_rd_0005");
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 13'h0005, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) req_b = 1'b0;
      if (ack_b === 1'b1) begin
        acks.push_back(k);
        total_cnt++;
        if (rdata_b !== 8'h5A) $display("FAIL w0_b2b_rdata cycle %0d got %h want 5a", k, rdata_b);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (acks.size() != 4) $display("FAIL w0_b2b_count got %0d want 4", acks.size());
    else pass_cnt++;
    for (int i = 0; i < acks.size(); i++) begin
      total_cnt++;
      if (acks[i] != 2 * i + 1) $display("FAIL w0_b2b_spacing ack %0d at cycle %0d want %0d", i, acks[i], 2 * i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    bit          sel;
    logic        w;
    logic [12:0] a;
    logic [7:0]  d;
    for (int i = 0; i < 40; i++) begin
      sel = 1'($urandom_range(0, 1));
      d   = 8'($urandom);
      if (sel) w = (wr_b.size() == 0) || ($urandom_range(0, 1) == 1);
      else     w = (wr_a.size() == 0) || ($urandom_range(0, 1) == 1);
      if (w) begin
        a = 13'($urandom);
        if (sel) wr_b.push_back(a); else wr_a.push_back(a);
      end else begin
        if (sel) a = wr_b[$urandom_range(0, wr_b.size() - 1)];
        else     a = wr_a[$urandom_range(0, wr_a.size() - 1)];
      end
      txn(sel, w, a, d, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 13'h0100, 8'h77);
    drive(1'b1, 1'b0, 1'b0, 13'h0000, 8'h00);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_input_change();
    test_reset_mid_write();
    test_w0();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
